// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, register-file read, writeback and output bundle
// for operand_fetch; slave is the fetch stage's view, master the environment's.
interface operand_fetch_if #(
    parameter int OP_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [1:0]      in_src0;
    logic [1:0]      in_src1;
    logic            in_src0_en;
    logic            in_src1_en;
    logic [1:0]      in_dst;
    logic            in_dst_en;

    logic [1:0]      rf_rd_sel_0;
    logic [1:0]      rf_rd_sel_1;
    logic            rf_rd_en_0;
    logic            rf_rd_en_1;
    logic [7:0]      rf_rd_data_0;
    logic [7:0]      rf_rd_data_1;

    logic            wb_en;
    logic [1:0]      wb_sel;

    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_op;
    logic [7:0]      out_opnd0;
    logic [7:0]      out_opnd1;
    logic [1:0]      out_dst;
    logic            out_dst_en;

    modport slave (
        input  in_valid, in_op, in_src0, in_src1, in_src0_en, in_src1_en,
               in_dst, in_dst_en,
        output in_ready,
        output rf_rd_sel_0, rf_rd_sel_1, rf_rd_en_0, rf_rd_en_1,
        input  rf_rd_data_0, rf_rd_data_1,
        input  wb_en, wb_sel,
        output out_valid, out_op, out_opnd0, out_opnd1, out_dst, out_dst_en,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_src0, in_src1, in_src0_en, in_src1_en,
               in_dst, in_dst_en,
        input  in_ready,
        input  rf_rd_sel_0, rf_rd_sel_1, rf_rd_en_0, rf_rd_en_1,
        output rf_rd_data_0, rf_rd_data_1,
        output wb_en, wb_sel,
        input  out_valid, out_op, out_opnd0, out_opnd1, out_dst, out_dst_en,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: register-file read front end presenting operands plus op tag.
// Define OPFETCH_SCOREBOARD_EN to add the pending-write RAW/WAW hazard stall.
module operand_fetch #(
    parameter int OP_W = 4
) (
    input logic            clk,
    input logic            reset,
    operand_fetch_if.slave bus
);
    logic            accept;
    logic            hz;
    logic            out_valid_q;
    logic            fresh;
    logic [OP_W-1:0] op_q;
    logic [1:0]      dst_q;
    logic            dst_en_q;
    logic [7:0]      opnd_q_0;
    logic [7:0]      opnd_q_1;

    assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~hz;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.rf_rd_en_0  = accept & bus.in_src0_en;
    assign bus.rf_rd_en_1  = accept & bus.in_src1_en;
    assign bus.rf_rd_sel_0 = bus.in_src0;
    assign bus.rf_rd_sel_1 = bus.in_src1;

`ifdef OPFETCH_SCOREBOARD_EN
    logic [3:0] pend;
    logic [3:0] wbclr;
    logic [3:0] set_mask;

    always_comb begin
        wbclr = '0;
        if (bus.wb_en)
            wbclr[bus.wb_sel] = 1'b1;
    end

    // A writeback landing this cycle already resolves the hazard it clears.
    always_comb begin
        hz = (bus.in_src0_en & pend[bus.in_src0] & ~wbclr[bus.in_src0])
           | (bus.in_src1_en & pend[bus.in_src1] & ~wbclr[bus.in_src1])
           | (bus.in_dst_en  & pend[bus.in_dst]  & ~wbclr[bus.in_dst]);
    end

    always_comb begin
        set_mask = '0;
        if (accept & bus.in_dst_en)
            set_mask[bus.in_dst] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend <= '0;
        else
            pend <= (pend & ~wbclr) | set_mask;
    end
`else
    logic unused_wb;

    assign hz        = 1'b0;
    assign unused_wb = ^{bus.wb_en, bus.wb_sel};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            fresh       <= 1'b0;
            op_q        <= '0;
            dst_q       <= '0;
            dst_en_q    <= 1'b0;
            opnd_q_0    <= '0;
            opnd_q_1    <= '0;
        end else begin
            fresh <= accept;
            if (accept) begin
                out_valid_q <= 1'b1;
                op_q        <= bus.in_op;
                dst_q       <= bus.in_dst;
                dst_en_q    <= bus.in_dst_en;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Register file drops its data after one cycle; hold it for stalls.
            if (fresh) begin
                opnd_q_0 <= bus.rf_rd_data_0;
                opnd_q_1 <= bus.rf_rd_data_1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_op     = op_q;
    assign bus.out_dst    = dst_q;
    assign bus.out_dst_en = dst_en_q;
    assign bus.out_opnd0  = fresh ? bus.rf_rd_data_0 : opnd_q_0;
    assign bus.out_opnd1  = fresh ? bus.rf_rd_data_1 : opnd_q_1;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table-driven bench with a register-file model and an
// output scoreboard queue; expectations follow OPFETCH_SCOREBOARD_EN.
module tb_operand_fetch;
    localparam int OP_W = 4;
`ifdef OPFETCH_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct {
        logic [3:0] op;
        logic [1:0] s0;
        logic       s0e;
        logic [1:0] s1;
        logic       s1e;
        logic [1:0] d;
        logic       de;
        logic       iv;
        logic       ord;
        logic       wbe;
        logic [1:0] wbs;
        logic [7:0] wbd;
        logic       rsb;
        logic       rnsb;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [1:0] d;
        logic       de;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] wb_data = 8'h00;
    logic [7:0] rf_mem [4] = '{default: 8'h00};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic m_ov = 1'b0;
    exp_t sbq[$];
    vec_t tv_a[$];
    vec_t tv_b[$];

    operand_fetch_if #(.OP_W(OP_W)) bus ();

    operand_fetch #(.OP_W(OP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file: registered read, zero when not enabled, same-cycle write forwarded.
    always @(posedge clk) begin
        bus.rf_rd_data_0 <= bus.rf_rd_en_0 ?
            ((bus.wb_en && bus.wb_sel == bus.rf_rd_sel_0) ? wb_data : rf_mem[bus.rf_rd_sel_0]) : 8'h00;
        bus.rf_rd_data_1 <= bus.rf_rd_en_1 ?
            ((bus.wb_en && bus.wb_sel == bus.rf_rd_sel_1) ? wb_data : rf_mem[bus.rf_rd_sel_1]) : 8'h00;
        if (bus.wb_en)
            rf_mem[bus.wb_sel] <= wb_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t ins(input int op, input int s0, input int s0e, input int s1,
                                 input int s1e, input int d, input int de, input int ord,
                                 input int rsb, input int rnsb);
        vec_t v;
        v.op = 4'(op);   v.s0 = 2'(s0); v.s0e = 1'(s0e); v.s1 = 2'(s1); v.s1e = 1'(s1e);
        v.d = 2'(d);     v.de = 1'(de); v.iv = 1'b1;      v.ord = 1'(ord);
        v.wbe = 1'b0;    v.wbs = 2'd0;  v.wbd = 8'h00;
        v.rsb = 1'(rsb); v.rnsb = 1'(rnsb);
        return v;
    endfunction

    function automatic vec_t with_wb(input vec_t vi, input int wbs, input int wbd);
        vec_t v = vi;
        v.wbe = 1'b1; v.wbs = 2'(wbs); v.wbd = 8'(wbd);
        return v;
    endfunction

    function automatic vec_t idle(input int wbe, input int wbs, input int wbd);
        vec_t v = ins(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        v.iv = 1'b0; v.wbe = 1'(wbe); v.wbs = 2'(wbs); v.wbd = 8'(wbd);
        return v;
    endfunction

    function automatic logic [7:0] rf_val(input vec_t v, input logic [1:0] s);
        return (v.wbe && v.wbs == s) ? v.wbd : rf_mem[s];
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.in_op = '0;
        bus.in_src0 = 2'd0; bus.in_src0_en = 1'b0;
        bus.in_src1 = 2'd0; bus.in_src1_en = 1'b0;
        bus.in_dst = 2'd0;  bus.in_dst_en = 1'b0;
        bus.wb_en = 1'b0;   bus.wb_sel = 2'd0; wb_data = 8'h00;
        bus.out_ready = 1'b1;
    endtask

    task automatic step(input vec_t v);
        logic rdy;
        logic acc;
        exp_t e;
        @(negedge clk);
        bus.in_valid = v.iv;  bus.in_op = v.op;
        bus.in_src0 = v.s0;   bus.in_src0_en = v.s0e;
        bus.in_src1 = v.s1;   bus.in_src1_en = v.s1e;
        bus.in_dst = v.d;     bus.in_dst_en = v.de;
        bus.wb_en = v.wbe;    bus.wb_sel = v.wbs; wb_data = v.wbd;
        bus.out_ready = v.ord;
        #1;
        rdy = SB ? v.rsb : v.rnsb;
        acc = v.iv & rdy;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        chk("rf_rd_en_0", 32'(bus.rf_rd_en_0), 32'(acc & v.s0e));
        chk("rf_rd_en_1", 32'(bus.rf_rd_en_1), 32'(acc & v.s1e));
        if (acc && v.s0e) chk("rf_rd_sel_0", 32'(bus.rf_rd_sel_0), 32'(v.s0));
        if (acc && v.s1e) chk("rf_rd_sel_1", 32'(bus.rf_rd_sel_1), 32'(v.s1));
        if (m_ov) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty cycle=%0d got=out_valid expected=no_output", cyc);
            end else begin
                e = sbq[0];
                chk("out_valid", 32'(bus.out_valid), 1);
                chk("out_op", 32'(bus.out_op), 32'(e.op));
                chk("out_opnd0", 32'(bus.out_opnd0), 32'(e.o0));
                chk("out_opnd1", 32'(bus.out_opnd1), 32'(e.o1));
                chk("out_dst", 32'(bus.out_dst), 32'(e.d));
                chk("out_dst_en", 32'(bus.out_dst_en), 32'(e.de));
                if (v.ord) void'(sbq.pop_front());
            end
        end else begin
            chk("out_valid_idle", 32'(bus.out_valid), 0);
        end
        if (acc) begin
            e.op = v.op;
            e.o0 = v.s0e ? rf_val(v, v.s0) : 8'h00;
            e.o1 = v.s1e ? rf_val(v, v.s1) : 8'h00;
            e.d  = v.d;
            e.de = v.de;
            sbq.push_back(e);
        end
        m_ov = acc ? 1'b1 : (v.ord ? 1'b0 : m_ov);
        cyc++;
    endtask

    initial begin
        // preload R0..R3 through writebacks to unpended registers
        tv_a.push_back(idle(1, 0, 8'h11));
        tv_a.push_back(idle(1, 1, 8'h5A));
        tv_a.push_back(idle(1, 2, 8'h22));
        tv_a.push_back(idle(1, 3, 8'h33));
        // single read of R1, second source disabled
        tv_a.push_back(ins(1, 1, 1, 0, 0, 0, 0, 1, 1, 1));
        tv_a.push_back(idle(0, 0, 0));
        // RAW on R2, released by a same-cycle writeback
        tv_a.push_back(ins(2, 0, 1, 0, 0, 2, 1, 1, 1, 1));
        tv_a.push_back(ins(3, 2, 1, 0, 0, 0, 0, 1, 0, 1));
        tv_a.push_back(with_wb(ins(3, 2, 1, 0, 0, 0, 0, 1, 1, 1), 2, 8'h77));
        tv_a.push_back(idle(0, 0, 0));
        // downstream stall for three cycles with another instruction waiting
        tv_a.push_back(ins(4, 0, 1, 3, 1, 0, 0, 1, 1, 1));
        for (int i = 0; i < 3; i++) tv_a.push_back(ins(5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tv_a.push_back(ins(5, 1, 1, 0, 0, 0, 0, 1, 1, 1));
        // back-to-back independent instructions
        tv_a.push_back(ins(6, 0, 0, 3, 1, 0, 0, 1, 1, 1));
        tv_a.push_back(ins(7, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        tv_a.push_back(ins(8, 2, 1, 2, 1, 0, 0, 1, 1, 1));
        tv_a.push_back(idle(0, 0, 0));
        // WAW on R1: set wins over the same-cycle clear
        tv_a.push_back(ins(9, 0, 0, 0, 0, 1, 1, 1, 1, 1));
        tv_a.push_back(ins(10, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        tv_a.push_back(with_wb(ins(10, 0, 0, 0, 0, 1, 1, 1, 1, 1), 1, 8'h66));
        tv_a.push_back(ins(11, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        tv_a.push_back(ins(12, 0, 0, 0, 0, 3, 1, 0, 1, 0));
        // after reset: stale pend must be gone; late writeback to R3 is harmless
        tv_b.push_back(with_wb(ins(13, 1, 1, 3, 1, 1, 1, 1, 1, 1), 3, 8'h44));
        tv_b.push_back(ins(14, 1, 1, 0, 0, 0, 0, 1, 0, 1));
        tv_b.push_back(ins(15, 3, 1, 0, 0, 3, 1, 1, 1, 1));
        tv_b.push_back(ins(16, 3, 1, 0, 0, 0, 0, 1, 0, 1));
        tv_b.push_back(idle(0, 0, 0));
        tv_b.push_back(idle(0, 0, 0));

        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_out_op", 32'(bus.out_op), 0);
        chk("reset_out_dst", 32'(bus.out_dst), 0);
        chk("reset_out_dst_en", 32'(bus.out_dst_en), 0);
        chk("reset_opnd0", 32'(bus.out_opnd0), 0);
        chk("reset_opnd1", 32'(bus.out_opnd1), 0);
        chk("reset_rd_en_0", 32'(bus.rf_rd_en_0), 0);
        chk("reset_rd_en_1", 32'(bus.rf_rd_en_1), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tv_a[i]) step(tv_a[i]);

        // asynchronous reset while an output is held and registers are pending
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 0);
        chk("midreset_in_ready", 32'(bus.in_ready), 1);
        sbq.delete();
        m_ov = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        foreach (tv_b[i]) step(tv_b[i]);

        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
